// File: rtl/tcs_color_classifier.sv
// -----------------------------------------------------------------------------
// tcs_color_classifier
// Latches one TCS34725 RGBC sample, computes each colour channel's 8-bit share
// of R+G+B with a single shared restoring divider, and classifies the sample
// into a colour code. Results are registered and held until the next sample.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-low reset
//   sample_valid  one-cycle strobe qualifying red/green/blue/clear
//   red/green/blue/clear  raw 16-bit sensor counts
//   busy          high from the cycle after acceptance until result_valid
//   result_valid  one-cycle pulse when new results are presented
//   color_code    0 DARK, 1 RED, 2 GREEN, 3 BLUE, 4 YELLOW, 5 WHITE
//   r_frac/g_frac/b_frac  floor(ch*256/sum), saturated to 255
//   drop_cnt      saturating count of strobes ignored while busy
// -----------------------------------------------------------------------------
module tcs_color_classifier #(
   parameter logic [15:0] DARK_THRESH  = 16'h0100,
   parameter logic [7:0]  DOM_THRESH   = 8'd128,
   parameter logic [7:0]  YEL_THRESH   = 8'd96,
   parameter logic [7:0]  BLUE_MAX_YEL = 8'd64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sample_valid,
   input  logic [15:0] red,
   input  logic [15:0] green,
   input  logic [15:0] blue,
   input  logic [15:0] clear,
   output logic        busy,
   output logic        result_valid,
   output logic [2:0]  color_code,
   output logic [7:0]  r_frac,
   output logic [7:0]  g_frac,
   output logic [7:0]  b_frac,
   output logic [7:0]  drop_cnt
);

   localparam int unsigned CH_W     = 16;
   localparam int unsigned SUM_W    = 18;
   localparam int unsigned FRAC_W   = 8;
   localparam int unsigned QUO_W    = 9;   // quotient range 0..256
   localparam int unsigned REM_W    = 19;  // partial remainder < 2*sum
   localparam int unsigned ITER_W   = 4;
   localparam int unsigned CNT_W    = 8;
   localparam int unsigned CODE_W   = 3;
   localparam int unsigned DIV_LAST = 8;   // 9 iterations per channel

   localparam logic [CODE_W-1:0] CODE_DARK   = 3'd0;
   localparam logic [CODE_W-1:0] CODE_RED    = 3'd1;
   localparam logic [CODE_W-1:0] CODE_GREEN  = 3'd2;
   localparam logic [CODE_W-1:0] CODE_BLUE   = 3'd3;
   localparam logic [CODE_W-1:0] CODE_YELLOW = 3'd4;
   localparam logic [CODE_W-1:0] CODE_WHITE  = 3'd5;

   typedef struct packed {
      logic [CH_W-1:0] red;
      logic [CH_W-1:0] green;
      logic [CH_W-1:0] blue;
      logic [CH_W-1:0] clear;
   } rgbc_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SUM,
      ST_DIV_R,
      ST_DIV_G,
      ST_DIV_B,
      ST_CLASSIFY
   } state_t;

   state_t              state_q, state_d;
   rgbc_t               smp_q, smp_d;
   logic [SUM_W-1:0]    sum_q, sum_d;
   logic                dark_q, dark_d;
   logic [REM_W-1:0]    rem_q, rem_d;
   logic [QUO_W-1:0]    quo_q, quo_d;
   logic [ITER_W-1:0]   iter_q, iter_d;
   logic [FRAC_W-1:0]   rf_q, rf_d, gf_q, gf_d, bf_q, bf_d;

   logic                busy_d, result_valid_d;
   logic [CODE_W-1:0]   color_code_d;
   logic [FRAC_W-1:0]   r_frac_d, g_frac_d, b_frac_d;
   logic [CNT_W-1:0]    drop_cnt_d;

   logic [SUM_W-1:0]    sum_c;
   logic                rem_ge_c;
   logic [REM_W-1:0]    rem_sub_c, rem_step_c;
   logic [QUO_W-1:0]    quo_step_c;
   logic [FRAC_W-1:0]   frac_sat_c;
   logic                div_last_c;
   logic [FRAC_W-1:0]   max_frac_c;
   logic [CODE_W-1:0]   dom_code_c, class_c;

   // R+G+B of the latched sample
   assign sum_c = SUM_W'(smp_q.red) + SUM_W'(smp_q.green) + SUM_W'(smp_q.blue);

   // One restoring-division step: compare, conditionally subtract, shift
   assign rem_ge_c   = (rem_q >= REM_W'(sum_q));
   assign rem_sub_c  = rem_ge_c ? (rem_q - REM_W'(sum_q)) : rem_q;
   assign rem_step_c = REM_W'({rem_sub_c, 1'b0});
   assign quo_step_c = QUO_W'({quo_q, rem_ge_c});
   assign frac_sat_c = quo_step_c[QUO_W-1] ? '1 : quo_step_c[FRAC_W-1:0];
   assign div_last_c = (iter_q == ITER_W'(DIV_LAST));

   // Classification in priority order; dominant-channel ties resolve R > G > B
   always_comb begin
      max_frac_c = rf_q;
      dom_code_c = CODE_RED;
      class_c    = CODE_WHITE;
      if ((rf_q >= gf_q) && (rf_q >= bf_q)) begin
         max_frac_c = rf_q;
         dom_code_c = CODE_RED;
      end else if (gf_q >= bf_q) begin
         max_frac_c = gf_q;
         dom_code_c = CODE_GREEN;
      end else begin
         max_frac_c = bf_q;
         dom_code_c = CODE_BLUE;
      end
      if (dark_q) begin
         class_c = CODE_DARK;
      end else if (max_frac_c >= DOM_THRESH) begin
         class_c = dom_code_c;
      end else if ((rf_q >= YEL_THRESH) && (gf_q >= YEL_THRESH) &&
                   (bf_q < BLUE_MAX_YEL)) begin
         class_c = CODE_YELLOW;
      end else begin
         class_c = CODE_WHITE;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d        = state_q;
      smp_d          = smp_q;
      sum_d          = sum_q;
      dark_d         = dark_q;
      rem_d          = rem_q;
      quo_d          = quo_q;
      iter_d         = iter_q;
      rf_d           = rf_q;
      gf_d           = gf_q;
      bf_d           = bf_q;
      busy_d         = busy;
      result_valid_d = 1'b0;
      color_code_d   = color_code;
      r_frac_d       = r_frac;
      g_frac_d       = g_frac;
      b_frac_d       = b_frac;
      drop_cnt_d     = drop_cnt;

      // Strobes outside IDLE are dropped and counted
      if (sample_valid && (state_q != ST_IDLE) && (drop_cnt != '1)) begin
         drop_cnt_d = drop_cnt + CNT_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (sample_valid) begin
               smp_d   = '{red: red, green: green, blue: blue, clear: clear};
               busy_d  = 1'b1;
               state_d = ST_SUM;
            end
         end

         ST_SUM: begin
            sum_d = sum_c;
            if ((smp_q.clear < DARK_THRESH) || (sum_c == '0)) begin
               dark_d  = 1'b1;
               rf_d    = '0;
               gf_d    = '0;
               bf_d    = '0;
               state_d = ST_CLASSIFY;
            end else begin
               dark_d  = 1'b0;
               rem_d   = REM_W'(smp_q.red);
               quo_d   = '0;
               iter_d  = '0;
               state_d = ST_DIV_R;
            end
         end

         ST_DIV_R, ST_DIV_G, ST_DIV_B: begin
            rem_d  = rem_step_c;
            quo_d  = quo_step_c;
            iter_d = iter_q + ITER_W'(1);
            if (div_last_c) begin
               quo_d  = '0;
               iter_d = '0;
               case (state_q)
                  ST_DIV_R: begin
                     rf_d    = frac_sat_c;
                     rem_d   = REM_W'(smp_q.green);
                     state_d = ST_DIV_G;
                  end
                  ST_DIV_G: begin
                     gf_d    = frac_sat_c;
                     rem_d   = REM_W'(smp_q.blue);
                     state_d = ST_DIV_B;
                  end
                  default: begin
                     bf_d    = frac_sat_c;
                     state_d = ST_CLASSIFY;
                  end
               endcase
            end
         end

         ST_CLASSIFY: begin
            color_code_d   = class_c;
            r_frac_d       = rf_q;
            g_frac_d       = gf_q;
            b_frac_d       = bf_q;
            result_valid_d = 1'b1;
            busy_d         = 1'b0;
            state_d        = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         smp_q        <= '0;
         sum_q        <= '0;
         dark_q       <= 1'b0;
         rem_q        <= '0;
         quo_q        <= '0;
         iter_q       <= '0;
         rf_q         <= '0;
         gf_q         <= '0;
         bf_q         <= '0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         color_code   <= '0;
         r_frac       <= '0;
         g_frac       <= '0;
         b_frac       <= '0;
         drop_cnt     <= '0;
      end else begin
         state_q      <= state_d;
         smp_q        <= smp_d;
         sum_q        <= sum_d;
         dark_q       <= dark_d;
         rem_q        <= rem_d;
         quo_q        <= quo_d;
         iter_q       <= iter_d;
         rf_q         <= rf_d;
         gf_q         <= gf_d;
         bf_q         <= bf_d;
         busy         <= busy_d;
         result_valid <= result_valid_d;
         color_code   <= color_code_d;
         r_frac       <= r_frac_d;
         g_frac       <= g_frac_d;
         b_frac       <= b_frac_d;
         drop_cnt     <= drop_cnt_d;
      end
   end

endmodule

// File: doc/tcs_color_classifier.md
# tcs_color_classifier

Downstream consumer of the TCS34725 RGBC reader. It latches one 16-bit red/green/blue/clear sample on a valid strobe. It then computes each colour channel's 8-bit share of the R+G+B sum with a shared sequential divider, and classifies the sample into one of six colour codes. Results are registered and held until the next sample completes, for use by display/actuator logic.

## Interface
- DARK_THRESH, 16'h0100: clear values below this classify as DARK.
- DOM_THRESH, 8'd128: minimum channel fraction for a single-colour (R/G/B) class.
- YEL_THRESH, 8'd96: minimum red and green fraction for YELLOW.
- BLUE_MAX_YEL, 8'd64: blue fraction must be below this for YELLOW.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- sample_valid  in  1  one-cycle strobe; red/green/blue/clear are valid in this cycle.
- red, green, blue, clear  in  16 each  raw sensor counts.
- busy  out  1  high from the cycle after acceptance until result_valid.
- result_valid  out  1  one-cycle pulse when new results are presented.
- color_code  out  3  0 DARK, 1 RED, 2 GREEN, 3 BLUE, 4 YELLOW, 5 WHITE; 6 and 7 are unused.
- r_frac, g_frac, b_frac  out  8 each  floor(ch*256/sum), saturated to 255.
- drop_cnt  out  8  saturating count of sample_valid strobes ignored while busy.

## Operation
- FSM states: IDLE, SUM, DIV_R, DIV_G, DIV_B, CLASSIFY.
- IDLE: when sample_valid is high, latch all four inputs and go to SUM; busy rises.
- SUM: compute sum = red+green+blue as an 18-bit unsigned value.
  - If clear < DARK_THRESH or sum == 0, go to CLASSIFY with all fractions forced to 0 and the DARK class.
  - Otherwise go to DIV_R.
- DIV_x: one restoring divider shared by all three channels, 9 iterations (9 cycles) per channel.
  - Quotient is floor(ch*256/sum), in the range 0..256.
  - A quotient of 256 saturates to 255.
  - Sequence is DIV_R, then DIV_G, then DIV_B.
- CLASSIFY: evaluate in priority order; the first match wins.
  1. Dark path → DARK (0).
  2. Largest fraction ≥ DOM_THRESH → RED, GREEN or BLUE for that channel. Ties resolve R > G > B.
  3. r_frac ≥ YEL_THRESH, g_frac ≥ YEL_THRESH and b_frac < BLUE_MAX_YEL → YELLOW (4).
  4. Otherwise → WHITE (5).
- On leaving CLASSIFY: register color_code and the three fractions, pulse result_valid, drop busy, return to IDLE.
- Outputs hold their values between results.
- sample_valid while not in IDLE:
  - The sample is ignored; latched data is not disturbed.
  - drop_cnt increments and saturates at 255.
- Fraction arithmetic is unsigned; there is no rounding, truncation only.

## Timing
- Reset (rst low, asynchronous): state IDLE, every output 0 (busy, result_valid, color_code, fractions, drop_cnt). Internal latches are cleared.
- Reset asserted mid-operation aborts immediately. No result_valid is issued, and the prior results are cleared to 0.
- Let cycle 0 be the cycle in which sample_valid is high in IDLE.
  - SUM runs in cycle 1.
  - Normal path: DIV occupies cycles 2–28 and CLASSIFY cycle 29. result_valid and the new outputs are visible in cycle 30; busy is high in cycles 1–29.
  - Dark path: CLASSIFY runs in cycle 2; result_valid is visible in cycle 3.
- A sample_valid in the same cycle that result_valid is high is accepted, because the FSM is already in IDLE.
- Back-to-back throughput: one sample per 30 cycles.

## Test plan
- Red sample: R=0x1000, G=0x0400, B=0x0400, C=0x2000 → result_valid at cycle 30; fractions 170/42/42; color_code 1.
- Dark sample: C=0x0050, any RGB → result_valid at cycle 3; color_code 0; fractions 0/0/0.
- Yellow sample: R=0x0800, G=0x0800, B=0x0100, C=0x2000 → fractions 120/120/15; color_code 4.
- Saturation and white:
  - R=0x0400, G=0, B=0, C=0x0800 → r_frac 255, color_code 1.
  - R=G=B=0x0300, C=0x1000 → fractions 85/85/85, color_code 5.
- Busy drop: second sample_valid at cycle 5 → ignored; drop_cnt=1; the cycle-30 result matches the first sample; a strobe coincident with result_valid is accepted.
- Reset mid-operation: assert rst at cycle 10 → all outputs 0 at once; no result_valid; a new sample after release completes normally.
